// File: rtl/i2s_frame_sched.sv
// I2S frame scheduler: stereo FIFO feeding a PCM5102A-style serializer.
// One {left, right} pair is fetched per LRCK frame; handles underrun and mute.
module i2s_frame_sched #(
  parameter int DEPTH            = 4,
  parameter bit HOLD_ON_UNDERRUN = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [15:0]              IN_LEFT,
  input  logic [15:0]              IN_RIGHT,
  input  logic                     MUTE,
  output logic                     SCK,
  output logic                     BCK,
  output logic                     LCK,
  output logic                     DIN,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [7:0]               UNDERRUN_CNT,
  output logic                     FRAME_STROBE
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    c;
  logic [15:0]   s;
  logic [15:0]   fl;
  logic [15:0]   fr;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_nxt;
  logic          full;
  logic          empty;
  logic          fetch;
  logic          push;
  logic          pop;
  logic [7:0]    ucnt;
  logic          strobe;

  assign fetch = (c == 8'hFF);
  // READY comes from the registered full flag, so a pop never frees a slot
  // for a push in the same cycle.
  assign push  = IN_VALID && !full;
  assign pop   = fetch && !empty;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !push)
      level_nxt = level - LW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c <= 8'd0;
    end else begin
      c <= c + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= {IN_LEFT, IN_RIGHT};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fl     <= 16'd0;
      fr     <= 16'd0;
      ucnt   <= 8'd0;
      strobe <= 1'b0;
    end else begin
      strobe <= fetch;
      if (fetch) begin
        if (empty && ucnt != 8'hFF)
          ucnt <= ucnt + 8'd1;
        if (MUTE) begin
          fl <= 16'd0;
          fr <= 16'd0;
        end else if (!empty) begin
          fl <= mem[rd_ptr][31:16];
          fr <= mem[rd_ptr][15:0];
        end else if (!HOLD_ON_UNDERRUN) begin
          fl <= 16'd0;
          fr <= 16'd0;
        end
      end
    end
  end

  // Loads land one BCK after each LCK edge, giving standard I2S alignment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s <= 16'd0;
    end else if (c[1:0] == 2'b11) begin
      if (c == 8'h03)
        s <= fl;
      else if (c == 8'h83)
        s <= fr;
      else
        s <= {s[14:0], 1'b0};
    end
  end

  assign SCK          = CLK;
  assign BCK          = c[1];
  assign LCK          = c[7];
  assign DIN          = s[15];
  assign IN_READY     = !full;
  assign LEVEL        = level;
  assign UNDERRUN_CNT = ucnt;
  assign FRAME_STROBE = strobe;

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Bench for i2s_frame_sched: two instances (hold / zero on underrun) checked
// every cycle against a frame-level model built from a queue and slot arithmetic.
module tb_i2s_frame_sched;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        mute;

  logic        ready_h, sck_h, bck_h, lck_h, din_h, strobe_h;
  logic [2:0]  level_h;
  logic [7:0]  ucnt_h;
  logic        ready_z, sck_z, bck_z, lck_z, din_z, strobe_z;
  logic [2:0]  level_z;
  logic [7:0]  ucnt_z;

  i2s_frame_sched #(.DEPTH(DEPTH), .HOLD_ON_UNDERRUN(1'b1)) dut_h (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(ready_h),
    .IN_LEFT(in_left), .IN_RIGHT(in_right), .MUTE(mute),
    .SCK(sck_h), .BCK(bck_h), .LCK(lck_h), .DIN(din_h),
    .LEVEL(level_h), .UNDERRUN_CNT(ucnt_h), .FRAME_STROBE(strobe_h)
  );

  i2s_frame_sched #(.DEPTH(DEPTH), .HOLD_ON_UNDERRUN(1'b0)) dut_z (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(ready_z),
    .IN_LEFT(in_left), .IN_RIGHT(in_right), .MUTE(mute),
    .SCK(sck_z), .BCK(bck_z), .LCK(lck_z), .DIN(din_z),
    .LEVEL(level_z), .UNDERRUN_CNT(ucnt_z), .FRAME_STROBE(strobe_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state: position in frame after the latest edge
  int          pos;
  logic [31:0] q[$];
  logic [15:0] fl_h, fr_h, fl_z, fr_z;
  int          ucnt;
  bit          strobe;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    q.delete();
    fl_h = 16'd0; fr_h = 16'd0; fl_z = 16'd0; fr_z = 16'd0;
    ucnt = 0;
    strobe = 1'b0;
  endtask

  task automatic model_edge();
    int n_before;
    logic [31:0] pr;
    n_before = q.size();
    strobe = (pos == 255);
    if (pos == 255) begin
      if (n_before == 0) begin
        if (ucnt < 255) ucnt++;
        if (mute) begin
          fl_h = 16'd0; fr_h = 16'd0;
        end
        fl_z = 16'd0; fr_z = 16'd0;
      end else begin
        pr = q.pop_front();
        if (mute) pr = 32'd0;
        fl_h = pr[31:16]; fr_h = pr[15:0];
        fl_z = pr[31:16]; fr_z = pr[15:0];
      end
    end
    if (in_valid && n_before < DEPTH)
      q.push_back({in_left, in_right});
    pos = (pos + 1) % 256;
  endtask

  // I2S slot rule: MSB in slot 1, LSB in slot 16, everything else zero
  function automatic logic exp_din(input int p, input logic [15:0] l, input logic [15:0] r);
    int slot;
    logic [15:0] smp;
    slot = (p / 4) % 32;
    smp = (p < 128) ? l : r;
    if (slot >= 1 && slot <= 16)
      return smp[16 - slot];
    return 1'b0;
  endfunction

  task automatic check_outputs();
    check_val("din_hold", 32'(din_h), 32'(exp_din(pos, fl_h, fr_h)));
    check_val("din_zero", 32'(din_z), 32'(exp_din(pos, fl_z, fr_z)));
    check_val("level", 32'(level_h), 32'(q.size()));
    check_val("level_z", 32'(level_z), 32'(q.size()));
    check_val("ready", 32'(ready_h), 32'(q.size() < DEPTH));
    check_val("bck", 32'(bck_h), 32'((pos / 2) % 2));
    check_val("lck", 32'(lck_h), 32'(pos >= 128));
    check_val("sck_low", 32'(sck_h), 32'd0);
    check_val("strobe", 32'(strobe_h), 32'(strobe));
    check_val("ucnt", 32'(ucnt_h), 32'(ucnt));
    check_val("ucnt_z", 32'(ucnt_z), 32'(ucnt));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_pos(input int target);
    int k;
    k = 0;
    while (pos != target && k < 300) begin
      cycle();
      k++;
    end
    check_val("wait_pos", 32'(pos), 32'(target));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    mute = 1'b0;
  endtask

  initial begin
    int n;
    int ucnt_saved;
    int vprob;
    bit mute_f;

    rst = 1'b1; in_valid = 1'b0; in_left = 16'd0; in_right = 16'd0; mute = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_level", 32'(level_h), 32'd0);
    check_val("rst_ready", 32'(ready_h), 32'd1);
    check_val("rst_din", 32'(din_h), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single pair with extreme bit patterns
    in_valid = 1'b1; in_left = 16'h8001; in_right = 16'h7FFE;
    cycle();
    idle();
    run(3 * 256);

    // continuous valid: fills to DEPTH then plays in order
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_left = 16'(i * 3 + 1); in_right = 16'(~(i * 5));
      cycle();
      if (i == 20) begin
        check_val("t2_full_level", 32'(level_h), 32'd4);
        check_val("t2_full_ready", 32'(ready_h), 32'd0);
      end
    end
    idle();

    // randomized traffic with random mute frames
    for (int f = 0; f < 12; f++) begin
      vprob = int'($urandom_range(0, 3));
      mute_f = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 256; i++) begin
        in_valid = ($urandom_range(0, 255) < 32'(vprob * 2));
        in_left = 16'($urandom);
        in_right = 16'($urandom);
        mute = mute_f;
        cycle();
      end
    end
    idle();
    run(6 * 256);

    // mute across a fetch with two pairs queued
    wait_pos(16);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_left = 16'hA5A5 + 16'(i); in_right = 16'h5A5A - 16'(i);
      cycle();
    end
    in_valid = 1'b0;
    ucnt_saved = ucnt;
    wait_pos(250);
    mute = 1'b1;
    wait_pos(1);
    mute = 1'b0;
    check_val("t4_level", 32'(level_h), 32'd1);
    check_val("t4_ucnt", 32'(ucnt_h), 32'(ucnt_saved));
    run(3 * 256);

    // push exactly on the fetch edge into an empty FIFO
    wait_pos(255);
    ucnt_saved = ucnt;
    in_valid = 1'b1; in_left = 16'hC3C3; in_right = 16'h3C3C;
    cycle();
    in_valid = 1'b0;
    check_val("t5_ucnt", 32'(ucnt_h), 32'(ucnt_saved + 1));
    check_val("t5_level", 32'(level_h), 32'd1);
    run(2 * 256);

    // async reset mid right channel with three pairs queued
    wait_pos(16);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_left = 16'h1111 * 16'(i + 1); in_right = 16'hF0F0 ^ 16'(i);
      cycle();
    end
    in_valid = 1'b0;
    check_val("t6_level_pre", 32'(level_h), 32'd3);
    wait_pos(8'h90);
    rst = 1'b1;
    #1;
    check_val("t6_din", 32'(din_h), 32'd0);
    check_val("t6_bck", 32'(bck_h), 32'd0);
    check_val("t6_lck", 32'(lck_h), 32'd0);
    check_val("t6_level", 32'(level_h), 32'd0);
    check_val("t6_ready", 32'(ready_h), 32'd1);
    check_val("t6_strobe", 32'(strobe_h), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!strobe_h && n < 600);
    check_val("t6_strobe_gap", 32'(n), 32'd256);

    // one pair, then starve long enough to saturate the underrun counter
    in_valid = 1'b1; in_left = 16'h1234; in_right = 16'h5678;
    cycle();
    idle();
    run(258 * 256);
    check_val("t3_ucnt_sat", 32'(ucnt_h), 32'd255);
    check_val("t3_ucnt_sat_z", 32'(ucnt_z), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
